// File: rtl/klt_pkg.sv
// Shared widths, tap layout and pipeline constants for the KLT gradient stage.
package klt_pkg;

    // Datapath widths
    localparam int PIX_W  = 8;
    localparam int CTX_W  = 11;
    localparam int GRAD_W = 9;
    localparam int SQ_W   = 16;
    localparam int XY_W   = 17;
    localparam int POS_W  = 11;

    // Bit positions inside a packed context tap
    localparam int DE_BIT  = 2;
    localparam int HS_BIT  = 1;
    localparam int VS_BIT  = 0;
    localparam int PIX_LSB = 3;

    // Context sample to result, in clock cycles
    localparam int GRAD_LAT = 3;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } flags_t;

    // Zero-extend both pixels so the difference covers -255..255 without overflow
    function automatic logic [GRAD_W-1:0] pix_diff(input logic [PIX_W-1:0] a,
                                                   input logic [PIX_W-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

endpackage

// File: rtl/klt_pos_counter.sv
// Frame position counters driven by the centre tap's de / v_sync flags.
// Outputs are the pre-increment position of the pixel presented this cycle.
module klt_pos_counter
    import klt_pkg::*;
#(
    parameter int H_SIZE = 800,
    parameter int V_SIZE = 600
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_de,
    input  logic             i_vs,
    output logic [POS_W-1:0] o_x,
    output logic [POS_W-1:0] o_y
);

    localparam logic [POS_W-1:0] X_MAX = POS_W'(H_SIZE - 1);
    localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_SIZE - 1);

    logic             r_de_prev;
    logic [POS_W-1:0] r_x;
    logic [POS_W-1:0] r_y;
    logic             w_de_fall;
    logic [POS_W-1:0] w_x_next;
    logic [POS_W-1:0] w_y_next;

    assign w_de_fall = r_de_prev & ~i_de;

    // Next-state: x counts active pixels and saturates; y counts line ends, v_sync clear wins
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (i_de) begin
            if (r_x < X_MAX) begin
                w_x_next = r_x + 1'b1;
            end
        end else if (w_de_fall) begin
            w_x_next = '0;
        end
        if (i_vs) begin
            w_y_next = '0;
        end else if (w_de_fall && (r_y < Y_MAX)) begin
            w_y_next = r_y + 1'b1;
        end
    end

    // Counter and edge-detect state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_de_prev <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
        end else begin
            r_de_prev <= i_de;
            r_x       <= w_x_next;
            r_y       <= w_y_next;
        end
    end

    assign o_x = r_x;
    assign o_y = r_y;

endmodule

// File: rtl/klt_gradient.sv
// KLT spatial gradients and structure-tensor products, fixed 3-stage pipeline.
// Sync flags and frame position ride alongside the arithmetic.
module klt_gradient
    import klt_pkg::*;
#(
    parameter int H_SIZE = 800,
    parameter int V_SIZE = 600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              context_valid,
    input  logic [CTX_W-1:0]  center,
    input  logic [CTX_W-1:0]  up,
    input  logic [CTX_W-1:0]  down,
    input  logic [CTX_W-1:0]  left,
    input  logic [CTX_W-1:0]  right,
    output logic              grad_valid,
    output logic [GRAD_W-1:0] ix,
    output logic [GRAD_W-1:0] iy,
    output logic [SQ_W-1:0]   ixx,
    output logic [SQ_W-1:0]   iyy,
    output logic [XY_W-1:0]   ixy,
    output logic              de_out,
    output logic              h_sync_out,
    output logic              v_sync_out,
    output logic [POS_W-1:0]  x_pos,
    output logic [POS_W-1:0]  y_pos
);

    // Stage 0 combinational
    logic [GRAD_W-1:0] w_ix;
    logic [GRAD_W-1:0] w_iy;
    flags_t            w_flags;
    logic [POS_W-1:0]  w_x_cnt;
    logic [POS_W-1:0]  w_y_cnt;
    logic              w_unused_taps;

    // Stage 1
    logic              r1_valid;
    logic [GRAD_W-1:0] r1_ix;
    logic [GRAD_W-1:0] r1_iy;
    flags_t            r1_flags;
    logic [POS_W-1:0]  r1_x;
    logic [POS_W-1:0]  r1_y;

    // Stage 1 -> 2 products
    logic signed [SQ_W-1:0] w_ix_sq;
    logic signed [SQ_W-1:0] w_iy_sq;
    logic signed [XY_W-1:0] w_ix_xy;
    logic signed [XY_W-1:0] w_iy_xy;
    logic [SQ_W-1:0]        w_ixx;
    logic [SQ_W-1:0]        w_iyy;
    logic [XY_W-1:0]        w_ixy;

    // Stage 2
    logic              r2_valid;
    logic [GRAD_W-1:0] r2_ix;
    logic [GRAD_W-1:0] r2_iy;
    logic [SQ_W-1:0]   r2_ixx;
    logic [SQ_W-1:0]   r2_iyy;
    logic [XY_W-1:0]   r2_ixy;
    flags_t            r2_flags;
    logic [POS_W-1:0]  r2_x;
    logic [POS_W-1:0]  r2_y;

    // Stage 3 (outputs)
    logic              r3_valid;
    logic [GRAD_W-1:0] r3_ix;
    logic [GRAD_W-1:0] r3_iy;
    logic [SQ_W-1:0]   r3_ixx;
    logic [SQ_W-1:0]   r3_iyy;
    logic [XY_W-1:0]   r3_ixy;
    flags_t            r3_flags;
    logic [POS_W-1:0]  r3_x;
    logic [POS_W-1:0]  r3_y;

    assign w_ix    = pix_diff(right[PIX_LSB +: PIX_W], left[PIX_LSB +: PIX_W]);
    assign w_iy    = pix_diff(down[PIX_LSB +: PIX_W], up[PIX_LSB +: PIX_W]);
    assign w_flags = '{de: center[DE_BIT], hs: center[HS_BIT], vs: center[VS_BIT]};

    // Neighbour flags and the centre pixel value are not needed here
    assign w_unused_taps = ^{center[CTX_W-1:PIX_LSB], up[PIX_LSB-1:0], down[PIX_LSB-1:0],
                             left[PIX_LSB-1:0], right[PIX_LSB-1:0]};

    klt_pos_counter #(
        .H_SIZE (H_SIZE),
        .V_SIZE (V_SIZE)
    ) u_pos_counter (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_de    (center[DE_BIT]),
        .i_vs    (center[VS_BIT]),
        .o_x     (w_x_cnt),
        .o_y     (w_y_cnt)
    );

    // Stage 1: register gradients, qualifier, centre flags and pre-increment position
    always_ff @(posedge clk) begin
        if (!rst) begin
            r1_valid <= 1'b0;
            r1_ix    <= '0;
            r1_iy    <= '0;
            r1_flags <= '0;
            r1_x     <= '0;
            r1_y     <= '0;
        end else begin
            r1_valid <= context_valid;
            r1_ix    <= w_ix;
            r1_iy    <= w_iy;
            r1_flags <= w_flags;
            r1_x     <= w_x_cnt;
            r1_y     <= w_y_cnt;
        end
    end

    // Sign-extend so each product is computed at its final width; results fit exactly
    assign w_ix_sq = {{(SQ_W - GRAD_W){r1_ix[GRAD_W-1]}}, r1_ix};
    assign w_iy_sq = {{(SQ_W - GRAD_W){r1_iy[GRAD_W-1]}}, r1_iy};
    assign w_ix_xy = {{(XY_W - GRAD_W){r1_ix[GRAD_W-1]}}, r1_ix};
    assign w_iy_xy = {{(XY_W - GRAD_W){r1_iy[GRAD_W-1]}}, r1_iy};
    assign w_ixx   = w_ix_sq * w_ix_sq;
    assign w_iyy   = w_iy_sq * w_iy_sq;
    assign w_ixy   = w_ix_xy * w_iy_xy;

    // Stage 2: register products; an invalid beat carries zero arithmetic but live flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r2_valid <= 1'b0;
            r2_ix    <= '0;
            r2_iy    <= '0;
            r2_ixx   <= '0;
            r2_iyy   <= '0;
            r2_ixy   <= '0;
            r2_flags <= '0;
            r2_x     <= '0;
            r2_y     <= '0;
        end else begin
            r2_valid <= r1_valid;
            r2_ix    <= r1_valid ? r1_ix : '0;
            r2_iy    <= r1_valid ? r1_iy : '0;
            r2_ixx   <= r1_valid ? w_ixx : '0;
            r2_iyy   <= r1_valid ? w_iyy : '0;
            r2_ixy   <= r1_valid ? w_ixy : '0;
            r2_flags <= r1_flags;
            r2_x     <= r1_x;
            r2_y     <= r1_y;
        end
    end

    // Stage 3: output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r3_valid <= 1'b0;
            r3_ix    <= '0;
            r3_iy    <= '0;
            r3_ixx   <= '0;
            r3_iyy   <= '0;
            r3_ixy   <= '0;
            r3_flags <= '0;
            r3_x     <= '0;
            r3_y     <= '0;
        end else begin
            r3_valid <= r2_valid;
            r3_ix    <= r2_ix;
            r3_iy    <= r2_iy;
            r3_ixx   <= r2_ixx;
            r3_iyy   <= r2_iyy;
            r3_ixy   <= r2_ixy;
            r3_flags <= r2_flags;
            r3_x     <= r2_x;
            r3_y     <= r2_y;
        end
    end

    assign grad_valid = r3_valid;
    assign ix         = r3_ix;
    assign iy         = r3_iy;
    assign ixx        = r3_ixx;
    assign iyy        = r3_iyy;
    assign ixy        = r3_ixy;
    assign de_out     = r3_flags.de;
    assign h_sync_out = r3_flags.hs;
    assign v_sync_out = r3_flags.vs;
    assign x_pos      = r3_x;
    assign y_pos      = r3_y;

endmodule
